writeback_stage: RTL and testbench
==================================

# writeback_stage

Final stage of the rv32i pipeline. Takes completed instructions from the memory stage over a valid/ready handshake, waits for the variable-latency data-memory read response on loads, and aligns and extends the load data. It drives the register file write port (we/waddr/wdata) from registered outputs. It also suppresses writes to x0, flags misaligned or illegal loads, and keeps a retired-writeback counter.

## Interface
Parameters:
- CNT_W, default 32: width of the writeback counter.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst_n  in  1  reset; asynchronous, active-low.
- mem_valid  in  1  memory stage holds a valid instruction.
- mem_ready  out  1  stage can accept; registered.
- mem_rd  in  5  destination register index.
- mem_result  in  32  ALU result, or the load address for loads.
- mem_reg_write  in  1  instruction writes rd.
- mem_is_load  in  1  instruction is a load.
- mem_funct3  in  3  load width/sign encoding.
- dmem_rvalid  in  1  data-memory read response valid; single-cycle pulse.
- dmem_rdata  in  32  aligned 32-bit word containing the load address.
- rf_we  out  1  register file write enable; one-cycle pulse.
- rf_waddr  out  5  register file write index.
- rf_wdata  out  32  register file write data.
- load_err  out  1  one-cycle pulse on a misaligned or illegal load.
- spurious_rvalid  out  1  sticky; dmem_rvalid seen while no load was pending.
- wb_count  out  CNT_W  number of rf_we pulses issued; wraps modulo 2^CNT_W.

## Operation
- States:
  - RESET_HOLD: entered on reset; exits to IDLE on the first clock after rst_n deasserts.
  - IDLE.
  - WAIT_LOAD.
- mem_ready:
  - 1 in IDLE, 0 in RESET_HOLD and WAIT_LOAD.
  - Driven from a flop, so the transfer condition is mem_valid && mem_ready sampled at the edge.
- Accepted non-load:
  - Registers rf_we = mem_reg_write && (mem_rd != 0), rf_waddr = mem_rd, rf_wdata = mem_result.
  - Stays in IDLE.
- Accepted load:
  - Latches rd, reg_write, funct3 and offset = mem_result[1:0].
  - Moves to WAIT_LOAD and drives rf_we = 0.
- WAIT_LOAD with dmem_rvalid:
  - Data is extracted from dmem_rdata using the latched funct3 and offset.
  - 000 LB: byte at offset, sign-extended.
  - 001 LH: halfword at offset[1], sign-extended.
  - 010 LW: full word.
  - 100 LBU: byte, zero-extended.
  - 101 LHU: halfword, zero-extended.
- Error load:
  - Misaligned: LH/LHU with offset[0]=1, or LW with offset != 0.
  - Illegal: funct3 of 011, 110 or 111.
  - Response: rf_we = 0 and load_err = 1 for one cycle.
  - The load still completes: wait for rvalid, then return to IDLE.
- Valid load: rf_we = reg_write && (rd != 0), with rf_waddr and rf_wdata set from the latched rd and the extracted data.
- Leaving WAIT_LOAD: on the rvalid edge the state returns to IDLE and mem_ready goes to 1.
- Writes to x0:
  - rf_we is never asserted for rd = 0.
  - The instruction still retires without a write, and wb_count does not increment.
- dmem_rvalid outside WAIT_LOAD:
  - The response is ignored and spurious_rvalid is set to 1.
  - The flag clears only on reset.
- rf_waddr/rf_wdata hold their last values when rf_we = 0.
- wb_count increments by 1 on every edge that sets rf_we = 1.

## Timing
- Reset values: rf_we 0, rf_waddr 0, rf_wdata 0, load_err 0, spurious_rvalid 0, wb_count 0, mem_ready 0, state RESET_HOLD.
- Reset asserted mid-load: the pending load is dropped immediately and no write is issued. A late rvalid after reset sets spurious_rvalid.
- Non-load accepted at edge N: rf_we is high for the cycle after N.
- Throughput:
  - Non-loads: one per cycle.
  - Loads: one per (response latency + 1) cycles.
- Load accepted at edge N: the earliest rvalid is sampled at edge N+1. rvalid is not sampled in the acceptance cycle.
- rvalid sampled at edge M:
  - rf_we (or load_err) is high for the cycle after M.
  - mem_ready = 1 in the same cycle, so the next instruction can be accepted at edge M+1.
- Unbounded response latency: the stage stays in WAIT_LOAD indefinitely with mem_ready = 0.

## Test plan
- Reset then idle: all outputs at their reset values during reset; mem_ready = 1 one cycle after rst_n rises.
- Back-to-back ALU ops:
  - Stimulus: rd=5 with 0x0000_1234, then rd=6 with 0xFFFF_FFFF, on consecutive cycles.
  - Required: two consecutive rf_we pulses with matching waddr/wdata, and wb_count = 2.
- Load extension:
  - dmem_rdata = 0x8081_F27F. Stimulus: mem_result[1:0]=3, rvalid after 3 cycles.
  - LB: rf_wdata = 0xFFFF_FF80. LBU: rf_wdata = 0x0000_0080.
  - LH at offset 2: rf_wdata = 0xFFFF_8081. LHU at offset 2: rf_wdata = 0x0000_8081.
  - mem_ready is low throughout each wait.
- Error and x0:
  - LW at offset 2 → load_err pulse, no rf_we.
  - funct3=011 → load_err pulse.
  - ALU op with rd=0 → no rf_we, wb_count unchanged.
- Spurious response and reset mid-load:
  - rvalid while in IDLE → spurious_rvalid = 1.
  - Reset during WAIT_LOAD, then rvalid → no rf_we, and spurious_rvalid = 1 after the rvalid.
- Counter wrap: with CNT_W = 4, 17 writing instructions → wb_count = 1.

Source files
------------

// File: rtl/writeback_stage.sv
// writeback_stage: final rv32i pipeline stage.
// It accepts completed instructions and waits for load responses.
// It aligns and extends load data and drives the register file write
// port from flops. It also counts the register file writes it issues.
//
// Handshake: an instruction transfers on a rising edge where
// mem_valid && mem_ready are both high. mem_ready is a flop, so the
// stage commits to accepting one cycle ahead. mem_valid/mem_rd/... must
// be held stable while mem_valid is high and mem_ready is low.
module writeback_stage #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mem_valid,
  output logic             mem_ready,
  input  logic [4:0]       mem_rd,
  input  logic [31:0]      mem_result,
  input  logic             mem_reg_write,
  input  logic             mem_is_load,
  input  logic [2:0]       mem_funct3,
  input  logic             dmem_rvalid,
  input  logic [31:0]      dmem_rdata,
  output logic             rf_we,
  output logic [4:0]       rf_waddr,
  output logic [31:0]      rf_wdata,
  output logic             load_err,
  output logic             spurious_rvalid,
  output logic [CNT_W-1:0] wb_count,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    RESET_HOLD = 2'd0,
    IDLE       = 2'd1,
    WAIT_LOAD  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             mem_ready_q, mem_ready_d;
  logic             rf_we_q, rf_we_d;
  logic [4:0]       rf_waddr_q, rf_waddr_d;
  logic [31:0]      rf_wdata_q, rf_wdata_d;
  logic             load_err_q, load_err_d;
  logic             spurious_q, spurious_d;
  logic [CNT_W-1:0] count_q, count_d;
  // Load context captured at acceptance, used when the response arrives.
  logic [4:0]       ld_rd_q, ld_rd_d;
  logic             ld_we_q, ld_we_d;
  logic [2:0]       ld_f3_q, ld_f3_d;
  logic [1:0]       ld_off_q, ld_off_d;

  logic [7:0]       ld_byte;
  logic [15:0]      ld_half;
  logic [31:0]      ld_data;
  logic             ld_bad;

  // Select the addressed byte/halfword and apply sign or zero extension.
  always_comb begin
    ld_byte = 8'h00;
    case (ld_off_q)
      2'd0:    ld_byte = dmem_rdata[7:0];
      2'd1:    ld_byte = dmem_rdata[15:8];
      2'd2:    ld_byte = dmem_rdata[23:16];
      default: ld_byte = dmem_rdata[31:24];
    endcase
    ld_half = ld_off_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    ld_data = 32'h0;
    ld_bad  = 1'b0;
    case (ld_f3_q)
      3'b000: ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b001: begin
        ld_data = {{16{ld_half[15]}}, ld_half};
        ld_bad  = ld_off_q[0];
      end
      3'b010: begin
        ld_data = dmem_rdata;
        ld_bad  = (ld_off_q != 2'd0);
      end
      3'b100: ld_data = {24'h0, ld_byte};
      3'b101: begin
        ld_data = {16'h0, ld_half};
        ld_bad  = ld_off_q[0];
      end
      default: ld_bad = 1'b1;
    endcase
  end

  // Next-state and next-output logic for the writeback FSM.
  always_comb begin
    state_d    = state_q;
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    load_err_d = 1'b0;
    spurious_d = spurious_q;
    ld_rd_d    = ld_rd_q;
    ld_we_d    = ld_we_q;
    ld_f3_d    = ld_f3_q;
    ld_off_d   = ld_off_q;
    case (state_q)
      RESET_HOLD: begin
        state_d = IDLE;
        if (dmem_rvalid) spurious_d = 1'b1;
      end
      IDLE: begin
        if (dmem_rvalid) spurious_d = 1'b1;
        if (mem_valid && mem_ready_q) begin
          if (mem_is_load) begin
            ld_rd_d  = mem_rd;
            ld_we_d  = mem_reg_write;
            ld_f3_d  = mem_funct3;
            ld_off_d = mem_result[1:0];
            state_d  = WAIT_LOAD;
          end else begin
            rf_we_d = mem_reg_write && (mem_rd != 5'd0);
            if (rf_we_d) begin
              rf_waddr_d = mem_rd;
              rf_wdata_d = mem_result;
            end
          end
        end
      end
      WAIT_LOAD: begin
        if (dmem_rvalid) begin
          state_d = IDLE;
          if (ld_bad) begin
            load_err_d = 1'b1;
          end else begin
            rf_we_d = ld_we_q && (ld_rd_q != 5'd0);
            if (rf_we_d) begin
              rf_waddr_d = ld_rd_q;
              rf_wdata_d = ld_data;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
    mem_ready_d = (state_d == IDLE);
    count_d     = count_q + {{(CNT_W-1){1'b0}}, rf_we_d};
  end

  // State and output registers; reset drops any pending load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RESET_HOLD;
      mem_ready_q <= 1'b0;
      rf_we_q     <= 1'b0;
      rf_waddr_q  <= 5'd0;
      rf_wdata_q  <= 32'h0;
      load_err_q  <= 1'b0;
      spurious_q  <= 1'b0;
      count_q     <= '0;
      ld_rd_q     <= 5'd0;
      ld_we_q     <= 1'b0;
      ld_f3_q     <= 3'd0;
      ld_off_q    <= 2'd0;
    end else begin
      state_q     <= state_d;
      mem_ready_q <= mem_ready_d;
      rf_we_q     <= rf_we_d;
      rf_waddr_q  <= rf_waddr_d;
      rf_wdata_q  <= rf_wdata_d;
      load_err_q  <= load_err_d;
      spurious_q  <= spurious_d;
      count_q     <= count_d;
      ld_rd_q     <= ld_rd_d;
      ld_we_q     <= ld_we_d;
      ld_f3_q     <= ld_f3_d;
      ld_off_q    <= ld_off_d;
    end
  end

  assign mem_ready       = mem_ready_q;
  assign rf_we           = rf_we_q;
  assign rf_waddr        = rf_waddr_q;
  assign rf_wdata        = rf_wdata_q;
  assign load_err        = load_err_q;
  assign spurious_rvalid = spurious_q;
  assign wb_count        = count_q;
  assign dbg_state       = state_q;

endmodule

// File: tb/tb_writeback_stage.sv
// tb_writeback_stage: directed bench for writeback_stage with a queue-based
// scoreboard. Drivers push expected writebacks; a negedge monitor pops them.
module tb_writeback_stage;
  localparam int CNT_W = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic             mem_valid = 1'b0;
  logic             mem_ready;
  logic [4:0]       mem_rd = 5'd0;
  logic [31:0]      mem_result = 32'h0;
  logic             mem_reg_write = 1'b0;
  logic             mem_is_load = 1'b0;
  logic [2:0]       mem_funct3 = 3'd0;
  logic             dmem_rvalid = 1'b0;
  logic [31:0]      dmem_rdata = 32'h0;
  logic             rf_we;
  logic [4:0]       rf_waddr;
  logic [31:0]      rf_wdata;
  logic             load_err;
  logic             spurious_rvalid;
  logic [CNT_W-1:0] wb_count;
  logic [1:0]       dbg_state;

  writeback_stage #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_rd(mem_rd), .mem_result(mem_result),
    .mem_reg_write(mem_reg_write), .mem_is_load(mem_is_load),
    .mem_funct3(mem_funct3),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .load_err(load_err), .spurious_rvalid(spurious_rvalid),
    .wb_count(wb_count), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  // Entry: {load_err, waddr, wdata}; error entries carry zero addr/data.
  logic [37:0]      exp_q[$];
  logic [37:0]      mon_act, mon_exp;
  logic [CNT_W-1:0] exp_cnt = '0;
  int               n_checks = 0;
  int               n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every writeback or error pulse must match the queue head.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && (rf_we === 1'b1 || load_err === 1'b1)) begin
      mon_act = {load_err, (rf_we ? {rf_waddr, rf_wdata} : 37'd0)};
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_wb: got 0x%0h expected no output at %0t", mon_act, $time);
      end else begin
        mon_exp = exp_q.pop_front();
        check("wb_out", mon_act, mon_exp);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_ready();
    int t = 0;
    while (mem_ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) check("ready_timeout", 64'd0, 64'd1);
  endtask

  task automatic alu(input logic [4:0] rd, input logic [31:0] val, input logic we);
    logic exp_we;
    exp_we = we && (rd != 5'd0);
    wait_ready();
    mem_valid = 1'b1; mem_rd = rd; mem_result = val;
    mem_reg_write = we; mem_is_load = 1'b0; mem_funct3 = 3'd0;
    if (exp_we) begin
      exp_q.push_back({1'b0, rd, val});
      exp_cnt++;
    end
    @(posedge clk);
    @(negedge clk);
    mem_valid = 1'b0;
    check("alu_we", {63'd0, rf_we}, {63'd0, exp_we});
  endtask

  task automatic load(input logic [4:0] rd, input logic [31:0] addr, input logic [2:0] f3,
                      input int lat, input logic [31:0] rdata,
                      input logic exp_err, input logic [31:0] exp_data);
    wait_ready();
    mem_valid = 1'b1; mem_rd = rd; mem_result = addr;
    mem_reg_write = 1'b1; mem_is_load = 1'b1; mem_funct3 = f3;
    @(posedge clk);
    @(negedge clk);
    mem_valid = 1'b0;
    for (int i = 0; i < lat; i++) begin
      check("ready_low_in_wait", {63'd0, mem_ready}, 64'd0);
      if (i == lat - 1) begin
        if (exp_err) exp_q.push_back({1'b1, 37'd0});
        else if (rd != 5'd0) begin
          exp_q.push_back({1'b0, rd, exp_data});
          exp_cnt++;
        end
        dmem_rvalid = 1'b1;
        dmem_rdata = rdata;
      end
      @(negedge clk);
    end
    dmem_rvalid = 1'b0;
    check("load_err_pulse", {63'd0, load_err}, {63'd0, exp_err});
    check("ready_after_load", {63'd0, mem_ready}, 64'd1);
  endtask

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    // Reset values
    repeat (2) @(negedge clk);
    check("rst_rf_we", {63'd0, rf_we}, 64'd0);
    check("rst_waddr", {59'd0, rf_waddr}, 64'd0);
    check("rst_wdata", {32'd0, rf_wdata}, 64'd0);
    check("rst_load_err", {63'd0, load_err}, 64'd0);
    check("rst_spurious", {63'd0, spurious_rvalid}, 64'd0);
    check("rst_wb_count", {60'd0, wb_count}, 64'd0);
    check("rst_ready", {63'd0, mem_ready}, 64'd0);
    check("rst_state", {62'd0, dbg_state}, 64'd0);
    rst_n = 1'b1;
    check("ready_before_edge", {63'd0, mem_ready}, 64'd0);
    @(negedge clk);
    check("ready_after_reset", {63'd0, mem_ready}, 64'd1);
    check("state_idle", {62'd0, dbg_state}, 64'd1);

    // Back-to-back ALU ops
    alu(5'd5, 32'h0000_1234, 1'b1);
    check("b2b_waddr0", {59'd0, rf_waddr}, 64'd5);
    alu(5'd6, 32'hFFFF_FFFF, 1'b1);
    check("b2b_waddr1", {59'd0, rf_waddr}, 64'd6);
    check("b2b_wdata1", {32'd0, rf_wdata}, 64'hFFFF_FFFF);
    check("b2b_count", {60'd0, wb_count}, 64'd2);

    // Load extension, offset 3 / 2, response after 3 cycles
    load(5'd7,  32'h0000_1003, 3'b000, 3, 32'h8081_F27F, 1'b0, 32'hFFFF_FF80);
    load(5'd8,  32'h0000_1003, 3'b100, 3, 32'h8081_F27F, 1'b0, 32'h0000_0080);
    load(5'd9,  32'h0000_1002, 3'b001, 3, 32'h8081_F27F, 1'b0, 32'hFFFF_8081);
    load(5'd10, 32'h0000_1002, 3'b101, 3, 32'h8081_F27F, 1'b0, 32'h0000_8081);
    load(5'd11, 32'h0000_1000, 3'b010, 1, 32'h8081_F27F, 1'b0, 32'h8081_F27F);
    load(5'd12, 32'h0000_1001, 3'b000, 2, 32'h8081_F27F, 1'b0, 32'hFFFF_FFF2);
    check("load_count", {60'd0, wb_count}, {60'd0, exp_cnt});

    // Error loads and x0
    load(5'd13, 32'h0000_1002, 3'b010, 2, 32'h1234_5678, 1'b1, 32'h0);
    load(5'd14, 32'h0000_1000, 3'b011, 1, 32'h1234_5678, 1'b1, 32'h0);
    load(5'd15, 32'h0000_1001, 3'b001, 1, 32'h1234_5678, 1'b1, 32'h0);
    alu(5'd0, 32'hDEAD_BEEF, 1'b1);
    alu(5'd3, 32'hCAFE_0000, 1'b0);
    check("x0_count", {60'd0, wb_count}, {60'd0, exp_cnt});

    // Spurious response in IDLE
    check("spur_clear", {63'd0, spurious_rvalid}, 64'd0);
    dmem_rvalid = 1'b1;
    @(negedge clk);
    dmem_rvalid = 1'b0;
    check("spur_idle", {63'd0, spurious_rvalid}, 64'd1);

    // Reset during WAIT_LOAD, then a late response
    wait_ready();
    mem_valid = 1'b1; mem_rd = 5'd20; mem_result = 32'h0;
    mem_reg_write = 1'b1; mem_is_load = 1'b1; mem_funct3 = 3'b010;
    @(posedge clk);
    @(negedge clk);
    mem_valid = 1'b0;
    check("midload_state", {62'd0, dbg_state}, 64'd2);
    rst_n = 1'b0;
    #1;
    exp_cnt = '0;
    check("midrst_ready", {63'd0, mem_ready}, 64'd0);
    check("midrst_spur", {63'd0, spurious_rvalid}, 64'd0);
    check("midrst_count", {60'd0, wb_count}, 64'd0);
    check("midrst_state", {62'd0, dbg_state}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    dmem_rvalid = 1'b1;
    dmem_rdata = 32'h5555_AAAA;
    @(negedge clk);
    dmem_rvalid = 1'b0;
    check("late_rvalid_spur", {63'd0, spurious_rvalid}, 64'd1);
    check("late_rvalid_no_we", {63'd0, rf_we}, 64'd0);

    // Counter wrap at CNT_W = 4
    for (int i = 0; i < 17; i++) alu(5'((i % 31) + 1), 32'(i * 3), 1'b1);
    check("wrap_count", {60'd0, wb_count}, 64'd1);
    check("wrap_model", {60'd0, wb_count}, {60'd0, exp_cnt});

    repeat (2) @(negedge clk);
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
